// File: rtl/seq_divider_pkg.sv
// Shared operand widths, iteration counts and width-mask helper for the
// iterative DIV/IDIV unit.
package seq_divider_pkg;
   localparam int unsigned DVD_W = 32;
   localparam int unsigned DVS_W = 16;
   localparam int unsigned CNT_W = 5;

   localparam logic [CNT_W-1:0] ITER_8  = 5'd8;
   localparam logic [CNT_W-1:0] ITER_16 = 5'd16;

   function automatic logic [DVS_W-1:0] f_width_mask(input logic is_8);
      return is_8 ? 16'h00FF : 16'hFFFF;
   endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring divider for DIV/IDIV: double-width dividend over single-width
// divisor, one quotient bit per cycle, with divide-error detection.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for start; operands latched and early errors caught
// S_DIVIDING | one restoring shift/subtract step per cycle
// S_FIXUP    | apply signs, signed range check, load result registers
// S_DONE     | complete pulse cycle, then back to idle
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_8_bit,
   input  logic             is_signed,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic [DVS_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             busy,
   output logic             complete,
   output logic             error
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVIDING,
      S_FIXUP,
      S_DONE
   } state_t;

   function automatic logic [31:0] f_cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [15:0] f_cond_neg16(input logic [15:0] v, input logic neg);
      return neg ? (~v + 16'd1) : v;
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [15:0]      r_rem;
   logic [15:0]      r_quo;
   logic [15:0]      r_div;
   logic             r_is8;
   logic             r_signed;
   logic             r_qsign;
   logic             r_dsign;
   logic [15:0]      r_quotient;
   logic [15:0]      r_remainder;
   logic             r_busy;
   logic             r_complete;
   logic             r_error;

   logic        w_dvd_neg;
   logic        w_dvs_neg;
   logic [31:0] w_dvd_ext;
   logic [31:0] w_dvd_mag;
   logic [15:0] w_dvs_ext;
   logic [15:0] w_dvs_mag;
   logic [15:0] w_hi_half;
   logic [15:0] w_lo_half;
   logic        w_early_err;

   logic        w_msb;
   logic [16:0] w_shift_rem;
   logic [16:0] w_diff;
   logic        w_sub_ok;
   logic [15:0] w_next_rem;

   logic [15:0] w_mask;
   logic [15:0] w_q_mag;
   logic [15:0] w_q_limit;
   logic        w_range_err;
   logic [15:0] w_q_final;
   logic [15:0] w_r_final;

   // Sign-extend the active operand width so one magnitude path serves both forms.
   assign w_dvd_neg   = is_signed & (is_8_bit ? dividend[15] : dividend[31]);
   assign w_dvs_neg   = is_signed & (is_8_bit ? divisor[7]   : divisor[15]);
   assign w_dvd_ext   = is_8_bit ? {{16{w_dvd_neg}}, dividend[15:0]} : dividend;
   assign w_dvs_ext   = is_8_bit ? {{8{w_dvs_neg}}, divisor[7:0]} : divisor;
   assign w_dvd_mag   = f_cond_neg32(w_dvd_ext, w_dvd_neg);
   assign w_dvs_mag   = f_cond_neg16(w_dvs_ext, w_dvs_neg);
   assign w_hi_half   = is_8_bit ? {8'h00, w_dvd_mag[15:8]} : w_dvd_mag[31:16];
   assign w_lo_half   = is_8_bit ? {8'h00, w_dvd_mag[7:0]}  : w_dvd_mag[15:0];
   assign w_early_err = (w_dvs_mag == 16'h0000) || (w_hi_half >= w_dvs_mag);

   // Partial remainder stays below the divisor, so the shifted value fits 17 bits
   // and the borrow out of the subtraction is the restore decision.
   assign w_msb       = r_is8 ? r_quo[7] : r_quo[15];
   assign w_shift_rem = {r_rem, w_msb};
   assign w_diff      = w_shift_rem - {1'b0, r_div};
   assign w_sub_ok    = ~w_diff[16];
   assign w_next_rem  = w_sub_ok ? w_diff[15:0] : w_shift_rem[15:0];

   assign w_mask      = f_width_mask(r_is8);
   assign w_q_mag     = r_quo & w_mask;
   assign w_q_limit   = r_is8 ? (r_qsign ? 16'h0080 : 16'h007F)
                              : (r_qsign ? 16'h8000 : 16'h7FFF);
   assign w_range_err = r_signed & (w_q_mag > w_q_limit);
   assign w_q_final   = f_cond_neg16(w_q_mag, r_qsign) & w_mask;
   assign w_r_final   = f_cond_neg16(r_rem, r_dsign) & w_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_is8       <= 1'b0;
         r_signed    <= 1'b0;
         r_qsign     <= 1'b0;
         r_dsign     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_complete  <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_complete <= 1'b0;
               if (start) begin
                  r_busy   <= 1'b1;
                  r_is8    <= is_8_bit;
                  r_signed <= is_signed;
                  r_qsign  <= w_dvd_neg ^ w_dvs_neg;
                  r_dsign  <= w_dvd_neg;
                  r_div    <= w_dvs_mag;
                  r_rem    <= w_hi_half;
                  r_quo    <= w_lo_half;
                  if (w_early_err) begin
                     r_quotient  <= '0;
                     r_remainder <= '0;
                     r_error     <= 1'b1;
                     r_complete  <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_error <= 1'b0;
                     r_count <= is_8_bit ? ITER_8 : ITER_16;
                     r_state <= S_DIVIDING;
                  end
               end
            end
            S_DIVIDING: begin
               r_rem   <= w_next_rem;
               r_quo   <= {r_quo[14:0], w_sub_ok};
               r_count <= r_count - 5'd1;
               if (r_count == 5'd1) begin
                  r_state <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               r_error     <= w_range_err;
               r_quotient  <= w_range_err ? 16'h0000 : w_q_final;
               r_remainder <= w_range_err ? 16'h0000 : w_r_final;
               r_complete  <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_complete <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign busy      = r_busy;
   assign complete  = r_complete;
   assign error     = r_error;

endmodule
